// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: active-low glyph patterns (G..A), digit codes
// and segment bit positions. Used by both the display driver and this decoder.
package seg_pkg;

  // Segment bit positions within a 7-bit segment bus
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Active-low glyph patterns, bit 6 = G ... bit 0 = A
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Recovered digit codes for non-numeric patterns
  localparam logic [4:0] DIG_BLANK = 5'h1F;
  localparam logic [4:0] DIG_ERR   = 5'h1E;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational segment-pattern to digit-code decoder. Unknown patterns map
// to DIG_ERR with err_o raised; blank maps to DIG_BLANK without error.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [4:0] code_o,
  output logic       err_o
);

  // Glyph lookup; anything outside the table is flagged as an error
  always_comb begin
    code_o = DIG_ERR;
    err_o  = 1'b0;
    case (seg_i)
      SEG_0:     code_o = 5'd0;
      SEG_1:     code_o = 5'd1;
      SEG_2:     code_o = 5'd2;
      SEG_3:     code_o = 5'd3;
      SEG_4:     code_o = 5'd4;
      SEG_5:     code_o = 5'd5;
      SEG_6:     code_o = 5'd6;
      SEG_7:     code_o = 5'd7;
      SEG_8:     code_o = 5'd8;
      SEG_9:     code_o = 5'd9;
      SEG_BLANK: code_o = DIG_BLANK;
      default: begin
        code_o = DIG_ERR;
        err_o  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Snoops a multiplexed active-low 7-segment bus and recovers, per digit
// position, the digit code and decimal point once a pattern has been seen
// unchanged for STABLE_CYCLES consecutive samples.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [6:0]            i_seg,
  input  logic                  i_decimal,
  input  logic [N_DIGITS-1:0]   i_an,
  output logic [5*N_DIGITS-1:0] o_digits,
  output logic [N_DIGITS-1:0]   o_dp,
  output logic                  o_valid,
  output logic [2:0]            o_index,
  output logic                  o_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e                state_q;
  logic [7:0]            cnt_q;
  logic [N_DIGITS-1:0]   s_an_q,   prev_an_q;
  logic [6:0]            s_seg_q,  prev_seg_q;
  logic                  s_dec_q,  prev_dec_q;
  logic [5*N_DIGITS-1:0] digits_q, digits_d;
  logic [N_DIGITS-1:0]   dp_q,     dp_d;
  logic                  valid_q,  err_q;
  logic [2:0]            index_q;

  logic [3:0]            zeros_s;
  logic [2:0]            pos_s;
  logic                  s_valid_s;
  logic                  same_s;
  logic [7:0]            cnt_inc_s;
  logic                  commit_s;
  logic [4:0]            code_s;
  logic                  code_err_s;

  seg_pattern_decode u_decode (
    .seg_i  (s_seg_q),
    .code_o (code_s),
    .err_o  (code_err_s)
  );

  // Count low anodes in the sample; a single low anode names the position
  always_comb begin
    zeros_s = 4'd0;
    pos_s   = 3'd0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (!s_an_q[k]) begin
        zeros_s = zeros_s + 4'd1;
        pos_s   = 3'(k);
      end else begin
        zeros_s = zeros_s;
      end
    end
    s_valid_s = (zeros_s == 4'd1);
  end

  // Stability tracking: compare with previous sample, saturating count, commit
  always_comb begin
    same_s    = (s_an_q == prev_an_q) && (s_seg_q == prev_seg_q) && (s_dec_q == prev_dec_q);
    cnt_inc_s = (cnt_q == 8'hFF) ? cnt_q : (cnt_q + 8'd1);
    commit_s  = (state_q == ST_TRACK) && s_valid_s && same_s &&
                (cnt_inc_s == 8'(STABLE_CYCLES));
  end

  // Next committed digit/dp vectors: only the committed position changes
  always_comb begin
    digits_d = digits_q;
    dp_d     = dp_q;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (commit_s && (pos_s == 3'(k))) begin
        digits_d[5*k +: 5] = code_s;
        dp_d[k]            = ~s_dec_q;
      end else begin
        digits_d[5*k +: 5] = digits_q[5*k +: 5];
        dp_d[k]            = dp_q[k];
      end
    end
  end

  // Input sample stage, stability FSM and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s_an_q     <= {N_DIGITS{1'b1}};
      s_seg_q    <= SEG_BLANK;
      s_dec_q    <= 1'b1;
      prev_an_q  <= {N_DIGITS{1'b1}};
      prev_seg_q <= SEG_BLANK;
      prev_dec_q <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      digits_q   <= {N_DIGITS{DIG_BLANK}};
      dp_q       <= {N_DIGITS{1'b0}};
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      index_q    <= 3'd0;
    end else begin
      s_an_q     <= i_an;
      s_seg_q    <= i_seg;
      s_dec_q    <= i_decimal;
      prev_an_q  <= s_an_q;
      prev_seg_q <= s_seg_q;
      prev_dec_q <= s_dec_q;
      digits_q   <= digits_d;
      dp_q       <= dp_d;
      valid_q    <= commit_s;
      err_q      <= commit_s & code_err_s;
      if (commit_s) begin
        index_q <= pos_s;
      end else begin
        index_q <= index_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (s_valid_s) begin
            state_q <= ST_TRACK;
            cnt_q   <= 8'd1;
          end else begin
            cnt_q   <= 8'd0;
          end
        end
        ST_TRACK: begin
          if (!s_valid_s) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
          end else if (same_s) begin
            cnt_q <= cnt_inc_s;
            if (commit_s) begin
              state_q <= ST_HOLD;
            end else begin
              state_q <= ST_TRACK;
            end
          end else begin
            cnt_q <= 8'd1;
          end
        end
        ST_HOLD: begin
          if (!s_valid_s) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
          end else if (!same_s) begin
            state_q <= ST_TRACK;
            cnt_q   <= 8'd1;
          end else begin
            state_q <= ST_HOLD;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 8'd0;
        end
      endcase
    end
  end

  assign o_digits = digits_q;
  assign o_dp     = dp_q;
  assign o_valid  = valid_q;
  assign o_index  = index_q;
  assign o_err    = err_q;

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the 7-segment display driver. Samples a time-multiplexed, active-low 7-segment bus (segments, decimal point, per-digit anode strobes) and recovers the digit value and decimal point for each position. Requires a pattern to be stable before committing it. Sits on the verification/loopback path and on boards that snoop an external display controller, turning segment patterns back into 5-bit digit codes for logic and scoreboards.

## Interface
Parameters:
- N_DIGITS, 4, number of multiplexed digit positions (1..8)
- STABLE_CYCLES, 8, consecutive identical samples required before commit (2..255)

Ports:
- i_clk  input  1  system clock; all logic on rising edge
- i_rst  input  1  reset, synchronous and active-high
- i_seg  input  7  segment lines, active-low (0 = lit); bit 0 = A … bit 6 = G
- i_decimal  input  1  decimal point, active-low
- i_an  input  N_DIGITS  anode strobes, active-low; bit k selects position k
- o_digits  output  5*N_DIGITS  committed digit code per position; position k at [5k+4:5k]
- o_dp  output  N_DIGITS  committed decimal point per position, active-high (1 = lit)
- o_valid  output  1  one-cycle pulse on each commit
- o_index  output  3  position written by the current/last commit
- o_err  output  1  one-cycle pulse with o_valid when the committed pattern is not a recognised glyph

## Operation
- Glyph table (active-low, G..A): 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, blank=7'h7F.
- Decode: glyph 0–9 -> code 0–9; blank -> 5'h1F; any other pattern -> 5'h1E with o_err.
- Inputs pass through one register stage (sample S) before any comparison.
- Sample is "valid" when exactly one bit of S.an is 0; position = index of that bit.
- FSM states:
  - IDLE: no valid sample. On a valid sample -> TRACK, count = 1.
  - TRACK: if S equals the previous sample in {an, seg, decimal}, count++. Otherwise restart (count = 1), or go to IDLE if S is invalid. When count reaches STABLE_CYCLES: commit -> HOLD.
  - HOLD: stays while S is unchanged. No further commits. Any change -> TRACK (count = 1) or IDLE (if invalid).
- Commit: write code into o_digits[position], write ~decimal into o_dp[position], set o_index = position, pulse o_valid (and o_err if unrecognised). Other positions are untouched.
- All-high or multi-low anodes (blanking or ghosting between strobes) are invalid and never commit.
- Counter saturates; it does not wrap.

## Timing
- Reset values: o_digits all 5'h1F, o_dp 0, o_valid 0, o_index 0, o_err 0, FSM IDLE, count 0.
- Latency: inputs constant and valid from edge t -> o_valid high in the cycle after edge t+STABLE_CYCLES. The committed outputs hold from that cycle on.
- A change on the same cycle count would reach STABLE_CYCLES restarts the count; no commit occurs.
- Pattern exactly STABLE_CYCLES-1 samples long never commits.
- Same position re-strobed with the same pattern after an invalid gap commits again (a fresh o_valid).
- i_rst mid-track or mid-HOLD: next cycle all outputs are at reset values. A stable pattern then needs the full latency again.
- o_valid and o_err never assert for more than one consecutive cycle for the same stable sample.

## Structure
- Shared package seg_pkg: glyph constants (SEG_0..SEG_9, SEG_BLANK), code constants (DIG_BLANK=5'h1F, DIG_ERR=5'h1E), and segment bit indices. The display driver imports the same package.
- Sub-module seg_pattern_decode: combinational pattern-to-code plus error flag, separately unit-testable.
- FSM state enum lives locally in seg_scan_decoder.

## Test plan
- Reset then hold i_an=4'b1110, i_seg=7'h24, i_decimal=1 for 8 cycles -> one o_valid, o_index=0, o_digits[4:0]=2, o_dp[0]=0; no pulse while held further.
- Hold i_an=4'b0111, i_seg=7'h10, i_decimal=0 for 7 cycles, then i_an=4'b1111 -> no o_valid; o_digits[19:15] stays 5'h1F.
- Scan 4 positions showing 1,2,3,4, each 10 cycles with 2-cycle all-high gaps -> four o_valid pulses at indices 0..3; o_digits = {4,3,2,1}.
- i_an=4'b1101, i_seg=7'h7E for 8 cycles -> o_valid and o_err together, o_digits[9:5]=5'h1E.
- i_an=4'b1100 (two low) with i_seg=7'h00 for 20 cycles -> no commit.
- Assert i_rst at count 5 of a stable 7'h30 pattern, release, keep pattern -> o_valid exactly 9 cycles after release edge (1 input register + 8 samples); all outputs at reset values before that.
